// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO.
// Pointers carry one bit beyond the address so full and empty can be told apart.
package fifo_pkg;

    localparam int PTR_WRAP_BITS = 1;

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: one synchronous write port, one read port.
// The array name memory is kept stable so benches can preload it by hierarchy.
module fifo_regfile #(
    parameter int FIFO_WIDTH = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [FIFO_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [FIFO_WIDTH-1:0] rdata
);

    logic [FIFO_WIDTH-1:0] memory [0:FIFO_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

    // Read data is sampled into the owner's output register on the read edge.
    assign rdata = memory[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with full/empty flags and a registered read port.
// Requests against a full (write) or empty (read) buffer are silently dropped.
module fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [FIFO_WIDTH-1:0] din,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + PTR_WRAP_BITS;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FIFO_WIDTH-1:0] rdata;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered pointers, so they reflect pre-edge state.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    fifo_regfile #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) rg (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: a vector table for fill/overflow/drain/streaming,
// plus hand sequences for asynchronous mid-run reset and full-with-read-and-write.
module tb_fifo;

    logic       clk;
    logic       rst;
    logic       wen;
    logic       ren;
    logic [3:0] din;
    logic [3:0] dout;
    logic       full;
    logic       empty;

    int checks;
    int errors;

    typedef struct {
        logic       wen;
        logic       ren;
        logic [3:0] din;
        logic [3:0] e_dout;
        logic       e_empty;
        logic       e_full;
    } vec_t;

    vec_t vecs [$];

    fifo #(.FIFO_WIDTH(4), .FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .ren   (ren),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] e_dout,
                           input logic e_empty, input logic e_full);
        chk({nm, ".dout"},  int'(dout),  int'(e_dout));
        chk({nm, ".empty"}, int'(empty), int'(e_empty));
        chk({nm, ".full"},  int'(full),  int'(e_full));
    endtask

    task automatic cyc(input logic w, input logic r, input logic [3:0] d);
        wen = w;
        ren = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic w, input logic r, input logic [3:0] d,
                       input logic [3:0] ed, input logic ee, input logic ef);
        vec_t v;
        v.wen = w; v.ren = r; v.din = d;
        v.e_dout = ed; v.e_empty = ee; v.e_full = ef;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Fill with 1..15,1; full only after the 16th write.
        for (int i = 0; i < 16; i++)
            add(1'b1, 1'b0, (i == 15) ? 4'd1 : 4'(i + 1), 4'd0, 1'b0, i == 15);
        // Overflow writes of 0 are dropped.
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        // Drain 18: 1..15,1 then two dropped reads hold dout at 1.
        for (int i = 0; i < 18; i++)
            add(1'b0, 1'b1, 4'd0, (i < 15) ? 4'(i + 1) : 4'd1, i >= 15, 1'b0);
        // Store 8 words 1..8.
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b0, 4'(i + 1), 4'd1, 1'b0, 1'b0);
        // Stream: word n holds (n+1) mod 16, read j returns word j.
        for (int j = 0; j < 20; j++)
            add(1'b1, 1'b1, 4'((9 + j) & 15), 4'((j + 1) & 15), 1'b0, 1'b0);
        // Drain remaining 8 (words 20..27 -> 5..12), then two reads on empty.
        for (int k = 0; k < 8; k++)
            add(1'b0, 1'b1, 4'd0, 4'(5 + k), k == 7, 1'b0);
        for (int k = 0; k < 2; k++)
            add(1'b0, 1'b1, 4'd0, 4'd12, 1'b1, 1'b0);

        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        din = 4'd0;
        #3;
        chk_all("reset", 4'd0, 1'b1, 1'b0);
        #4;
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].wen, vecs[i].ren, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_empty, vecs[i].e_full);
        end

        // Asynchronous reset with the buffer half full and dout non-zero.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 4'(k + 2));
        cyc(1'b0, 1'b1, 4'd0);
        chk_all("pre_rst", 4'd2, 1'b0, 1'b0);
        wen = 1'b0;
        ren = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 4'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 4'd0);
        chk_all("post_rst_rd", 4'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 4'd7);
        chk_all("post_rst_wr", 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'd0);
        chk_all("post_rst_rd2", 4'd7, 1'b1, 1'b0);

        // Full with both requests: only the read happens.
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 4'(k));
        chk_all("full16", 4'd7, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 4'd15);
        chk_all("full_rw", 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd9);
        chk_all("refill", 4'd0, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            cyc(1'b0, 1'b1, 4'd0);
            chk($sformatf("tail%0d", k), int'(dout), k);
        end
        cyc(1'b0, 1'b1, 4'd0);
        chk_all("tail_last", 4'd9, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
